// File: rtl/fa_seq_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package fa_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the nibble index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/fa_4bits.sv
// 4-bit ripple-carry adder used as the shared datapath of the sequencer.
module fa_4bits
  import fa_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i0,
  input  logic [NIBBLE_W-1:0] i1,
  input  logic                cin,
  output logic                cout,
  output logic [NIBBLE_W-1:0] sum
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign sum[i]       = i0[i] ^ i1[i] ^ carry[i];
    assign carry[i + 1] = (i0[i] & i1[i]) | (carry[i] & (i0[i] ^ i1[i]));
  end

  assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/fa_4bits_seq_ctrl.sv
// Wide adder built from one fa_4bits, one nibble per cycle, LSB first.
// Optional subtract mode is enabled by defining FA_SEQ_SUB_EN.
module fa_4bits_seq_ctrl
  import fa_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
`ifdef FA_SEQ_SUB_EN
  input  logic                          sub,
`endif
  output logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout
);

  localparam int unsigned IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e                             state_q;
  logic [IDX_W-1:0]                   idx_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   sum_q;
  logic                               c_q;
  logic                               cout_q;

  logic [NIBBLE_W-1:0]                nib_sum;
  logic                               nib_cout;

  fa_4bits u_fa (
    .i0   (a_q[idx_q]),
    .i1   (b_q[idx_q]),
    .cin  (c_q),
    .cout (nib_cout),
    .sum  (nib_sum)
  );

  // Handshake flags decode straight from the state register.
  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            idx_q   <= '0;
            a_q     <= a;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef FA_SEQ_SUB_EN
            // Two's-complement subtract: invert b and force the initial carry.
            b_q     <= sub ? ~b : b;
            c_q     <= sub | cin;
`else
            b_q     <= b;
            c_q     <= cin;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q[idx_q] <= nib_sum;
          c_q          <= nib_cout;
          idx_q        <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            cout_q  <= nib_cout;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_4bits_seq_ctrl.sv
// Scoreboard bench for fa_4bits_seq_ctrl with NIBBLES=4.
module tb_fa_4bits_seq_ctrl;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];

  fa_4bits_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef FA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("done_latency", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  // Called at a negedge: present a request, push its expected result when recorded.
  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic cv, input logic sv, input bit record);
    logic [W:0] full;
    exp_t       e;
    a     = av;
    b     = bv;
    cin   = cv;
    sub   = sv;
    start = 1'b1;
`ifdef FA_SEQ_SUB_EN
    if (sv) full = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
    else    full = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
`else
    full = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
`endif
    e.sum      = full[W-1:0];
    e.cout     = full[W];
    e.done_cyc = cyc + NIB + 1;
    if (record) exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Four RUN cycles with busy set, then the DONE cycle.
  task automatic run_body(input string tag);
    for (int k = 0; k < NIB; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_ready"}, 32'(ready), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_no_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    drive_start(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
    run_body("basic");
    idle_cycles(1);
    chk("idle_ready", 32'(ready), 32'd1);
    chk("held_sum", 32'(sum), 32'h0100);

    drive_start(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    run_body("wrap");
    idle_cycles(1);
    drive_start(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
    run_body("cin");
    idle_cycles(1);

    // Start pulse during RUN must be ignored.
    drive_start(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ign_busy0", 32'(busy), 32'd1);
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(negedge clk);
    chk("ign_ready", 32'(ready), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("ign_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ign_busy3", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ign_done", 32'(done), 32'd1);
    idle_cycles(NIB + 2);

    // Back-to-back: new start accepted in the DONE cycle.
    drive_start(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    run_body("b2b_first");
    drive_start(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
    run_body("b2b_second");
    idle_cycles(1);

    // Reset in the second RUN cycle aborts without a done pulse.
    drive_start(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    idle_cycles(NIB + 3);

`ifdef FA_SEQ_SUB_EN
    drive_start(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    run_body("sub_borrow");
    idle_cycles(1);
    drive_start(16'h0009, 16'h0003, 1'b0, 1'b1, 1'b1);
    run_body("sub_noborrow");
    idle_cycles(1);
`endif

    for (int r = 0; r < 6; r++) begin
      drive_start(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);
      run_body("rand");
    end
    idle_cycles(2);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
